seg7_scan_driver: RTL and testbench

//  Consumes the 32-bit debug word from the register debug mux and shows it as 8 hex digits on the board's time-multiplexed 7-segment display.
//  - Holds a per-frame snapshot so all 8 digits of one scan come from the same value (no tearing).
//  - Optional freeze input holds the displayed value.

---
 rtl/seg7_scan_driver.sv | 125 ++++++++++++
 tb/tb_seg7_scan_driver.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// Scans a 32-bit debug word onto an 8-digit multiplexed 7-segment display as hex.
// Optional build macro LEADING_ZERO_BLANK_EN blanks digits above the top non-zero nibble.
module seg7_scan_driver #(
  parameter int SCAN_DIV   = 100000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] dbg_data,
  input  logic        freeze,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_tick
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [31:0]      snap_q, snap_d;
  logic [7:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;
  logic             frame_tick_q, frame_tick_d;

  logic             tick;
  logic             frame;
  logic [3:0]       nibble;
  logic [6:0]       glyph;
  logic             digit_on;
  logic [7:0]       an_act;
  logic [6:0]       seg_act;
  logic             dp_act;

`ifdef LEADING_ZERO_BLANK_EN
  logic [7:0] nz;
  logic [2:0] msd;

  for (genvar gi = 0; gi < 8; gi++) begin : g_nz
    assign nz[gi] = |snap_q[4*gi +: 4];
  end

  // Digit 0 is always shown, so msd bottoms out at 0 even for an all-zero word.
  always_comb begin
    msd = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (nz[i]) msd = 3'(i);
    end
  end
`endif

  always_comb begin
    tick   = (cnt_q == CNT_MAX);
    frame  = tick && (idx_q == 3'd7);
    cnt_d  = tick ? '0 : cnt_q + CNT_W'(1);
    idx_d  = tick ? idx_q + 3'd1 : idx_q;
    frame_tick_d = frame;
    // Snapshot only at the frame boundary so one scan never mixes two words.
    snap_d = (frame && !freeze) ? dbg_data : snap_q;

    nibble = snap_q[{idx_q, 2'b00} +: 4];
    glyph  = 7'h00;
    case (nibble)
      4'h0: glyph = 7'h3F;
      4'h1: glyph = 7'h06;
      4'h2: glyph = 7'h5B;
      4'h3: glyph = 7'h4F;
      4'h4: glyph = 7'h66;
      4'h5: glyph = 7'h6D;
      4'h6: glyph = 7'h7D;
      4'h7: glyph = 7'h07;
      4'h8: glyph = 7'h7F;
      4'h9: glyph = 7'h6F;
      4'hA: glyph = 7'h77;
      4'hB: glyph = 7'h7C;
      4'hC: glyph = 7'h39;
      4'hD: glyph = 7'h5E;
      4'hE: glyph = 7'h79;
      4'hF: glyph = 7'h71;
      default: glyph = 7'h00;
    endcase

`ifdef LEADING_ZERO_BLANK_EN
    digit_on = (idx_q <= msd);
`else
    digit_on = 1'b1;
`endif

    an_act  = digit_on ? (8'd1 << idx_q) : 8'd0;
    seg_act = digit_on ? glyph : 7'd0;
    dp_act  = (idx_q == 3'd0) && freeze;

    an_d  = ACTIVE_LOW ? ~an_act  : an_act;
    seg_d = ACTIVE_LOW ? ~seg_act : seg_act;
    dp_d  = ACTIVE_LOW ? ~dp_act  : dp_act;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      idx_q        <= 3'd0;
      snap_q       <= 32'd0;
      frame_tick_q <= 1'b0;
      an_q         <= {8{ACTIVE_LOW}};
      seg_q        <= {7{ACTIVE_LOW}};
      dp_q         <= ACTIVE_LOW;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      snap_q       <= snap_d;
      frame_tick_q <= frame_tick_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomized bench for seg7_scan_driver (SCAN_DIV=4, ACTIVE_LOW=1) against a cycle-count model.
// Define LEADING_ZERO_BLANK_EN for both RTL and bench to exercise the blanking build.
module tb_seg7_scan_driver;

  localparam int SCAN_DIV = 4;
  localparam int FRAME    = 8 * SCAN_DIV;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] dbg_data;
  logic        freeze;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_tick;

  always #5 clk = ~clk;

  seg7_scan_driver #(.SCAN_DIV(SCAN_DIV), .ACTIVE_LOW(1'b1)) dut (
    .clk        (clk),
    .rst        (rst),
    .dbg_data   (dbg_data),
    .freeze     (freeze),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_tick (frame_tick)
  );

  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  logic [6:0] glyph_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Model: k counts clocks since reset release; digit = k/SCAN_DIV mod 8, frame ends every 32.
  int unsigned k = 0;
  logic [31:0] m_snap = 32'd0;
  logic [7:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_dp;
  logic        e_ft;
  bit          m_valid = 0;

  always @(posedge clk) begin : model
    int digit;
    int top;
    int nib;
    bit shown;
    if (rst) begin
      k      = 0;
      m_snap = 32'd0;
      e_an   = 8'hFF;
      e_seg  = 7'h7F;
      e_dp   = 1'b1;
      e_ft   = 1'b0;
    end else begin
      digit = (k / SCAN_DIV) % 8;
      nib   = (m_snap >> (4 * digit)) & 32'hF;
      top   = 0;
      for (int i = 0; i < 8; i++) if (((m_snap >> (4 * i)) & 32'hF) != 0) top = i;
`ifdef LEADING_ZERO_BLANK_EN
      shown = (digit <= top);
`else
      shown = 1'b1;
`endif
      e_an  = shown ? ~(8'd1 << digit) : 8'hFF;
      e_seg = shown ? ~glyph_tab[nib] : 7'h7F;
      e_dp  = !(digit == 0 && freeze);
      e_ft  = ((k % FRAME) == FRAME - 1);
      if (((k % FRAME) == FRAME - 1) && !freeze) m_snap = dbg_data;
      k++;
    end
    m_valid = 1;
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check_val("an",         an,         e_an);
      check_val("seg",        seg,        e_seg);
      check_val("dp",         dp,         e_dp);
      check_val("frame_tick", frame_tick, e_ft);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst      = 1'b1;
    freeze   = 1'b0;
    dbg_data = 32'd0;
    step(3);
    rst = 1'b0;
    $display("reset released, showing 00000000");
    step(40);
    dbg_data = 32'hDEADBEEF;
    $display("dbg_data=DEADBEEF");
    step(70);
    dbg_data = 32'h11111111;
    step(40);
    dbg_data = 32'h22222222;
    $display("dbg_data 11111111 -> 22222222 mid-frame");
    step(70);
    dbg_data = 32'hDEADBEEF;
    step(40);
    freeze   = 1'b1;
    dbg_data = 32'h12345678;
    $display("freeze=1, dbg_data=12345678");
    step(70);
    freeze = 1'b0;
    $display("freeze=0");
    step(70);
    dbg_data = 32'h000000A5;
    step(70);
    step($urandom_range(1, 20));
    rst = 1'b1;
    $display("mid-scan reset");
    step(1);
    rst = 1'b0;
    step(40);
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 7) == 0)
        dbg_data = ($urandom_range(0, 1) == 0) ? $urandom : ($urandom >> $urandom_range(0, 31));
      if ($urandom_range(0, 49) == 0) freeze = ~freeze;
      rst = ($urandom_range(0, 399) == 0);
      step(1);
    end
    rst = 1'b0;
    step(2);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
